// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg
// Shared definitions for the boot-time program loader: FSM state encodings
// and the default instruction-memory depth (in 32-bit words). The depth
// constant is also the one the instruction memory is sized from, so the
// loader and the memory cannot disagree on capacity.
package prog_loader_pkg;

  // Default instruction memory size in 32-bit words.
  localparam int IMEM_DEPTH_DEFAULT = 256;

  // Loader FSM states.
  typedef enum logic [2:0] {
    PL_LEN_LO = 3'd0,  // waiting for word-count low byte
    PL_LEN_HI = 3'd1,  // waiting for word-count high byte
    PL_DATA   = 3'd2,  // streaming image bytes
    PL_DONE   = 3'd3,  // image loaded, core released (terminal)
    PL_ERR    = 3'd4   // header too large, core held in reset (terminal)
  } pl_state_t;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// prog_loader_byte_packer
// Packs a little-endian byte stream into 32-bit words. The first byte of each
// group of four lands in bits [7:0]. When the fourth byte is accepted the
// completed word is registered and word_valid pulses for one cycle; the word
// register then holds its value until the next completed word.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-low reset (clears everything)
//   clear      in   restarts packing (byte index and shift register) but
//                   keeps the last completed word on word_data
//   byte_valid in   accept byte_data this cycle
//   byte_data  in   [7:0] stream byte
//   last_byte  out  the next accepted byte completes a word
//   word_valid out  one-cycle pulse, word_data is a freshly completed word
//   word_data  out  [31:0] last completed word
module prog_loader_byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        last_byte,
  output logic        word_valid,
  output logic [31:0] word_data
);

  logic [31:0] shift_reg;
  logic [1:0]  byte_idx_reg;
  logic        word_valid_reg;
  logic [31:0] word_data_reg;

  assign last_byte  = (byte_idx_reg == 2'd3);
  assign word_valid = word_valid_reg;
  assign word_data  = word_data_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      shift_reg      <= '0;
      byte_idx_reg   <= '0;
      word_valid_reg <= 1'b0;
      word_data_reg  <= '0;
    end else begin
      word_valid_reg <= 1'b0;
      if (clear) begin
        shift_reg    <= '0;
        byte_idx_reg <= '0;
      end else if (byte_valid) begin
        // Shift right so that after four bytes the first one sits at [7:0].
        shift_reg    <= {byte_data, shift_reg[31:8]};
        byte_idx_reg <= byte_idx_reg + 2'd1;
        if (byte_idx_reg == 2'd3) begin
          word_data_reg  <= {byte_data, shift_reg[31:8]};
          word_valid_reg <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// prog_loader
// Boot-time program loader in front of the single-cycle RV32I core. Accepts a
// byte stream (16-bit little-endian word count N, then N little-endian 32-bit
// words), writes the words to instruction memory at addresses 0..N-1, and
// holds the core in reset until the last word has been committed.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-low reset, highest priority
//   in_valid   in   a byte is present on in_data
//   in_data    in   [7:0] stream byte
//   in_ready   out  loader accepts a byte (transfer = in_valid && in_ready)
//   imem_we    out  one-cycle instruction-memory write strobe
//   imem_addr  out  [ADDR_W-1:0] word address of the write
//   imem_wdata out  [31:0] word to write
//   core_rst   out  active-high reset to the core; low only once loaded
//   done       out  image loaded, core released
//   err        out  length header exceeded IMEM_DEPTH
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int IMEM_DEPTH = IMEM_DEPTH_DEFAULT,
  parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              err
);

  localparam logic [16:0] DEPTH_EXT = 17'(IMEM_DEPTH);

  pl_state_t state_reg, state_next;

  logic [7:0]        len_lo_reg;
  logic [15:0]       len_reg;
  // One bit wider than the address so a full-depth image counts to
  // IMEM_DEPTH without wrapping.
  logic [ADDR_W:0]   word_cnt_reg;
  logic [ADDR_W-1:0] imem_addr_reg;
  logic              core_rst_reg;
  logic              done_reg;
  logic              err_reg;

  logic        transfer;
  logic [15:0] hdr_len;
  logic        hdr_oversize;
  logic        start_data;
  logic        data_byte;
  logic        last_byte;
  logic        word_done;
  logic        word_valid;
  logic [31:0] word_data;
  logic [15:0] word_cnt_ext;
  logic        last_word;

  assign in_ready = rst && ((state_reg == PL_LEN_LO) ||
                            (state_reg == PL_LEN_HI) ||
                            (state_reg == PL_DATA));
  assign transfer = in_valid && in_ready;

  // Full header as seen on the LEN_HI transfer.
  assign hdr_len      = {in_data, len_lo_reg};
  assign hdr_oversize = ({1'b0, hdr_len} > DEPTH_EXT);
  assign start_data   = (state_reg == PL_LEN_HI) && transfer &&
                        (hdr_len != 16'd0) && !hdr_oversize;

  assign data_byte    = (state_reg == PL_DATA) && transfer;
  assign word_done    = data_byte && last_byte;
  assign word_cnt_ext = 16'(word_cnt_reg);
  // len_reg is at least 1 whenever DATA is active.
  assign last_word    = (word_cnt_ext == (len_reg - 16'd1));

  prog_loader_byte_packer u_byte_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_data),
    .byte_valid (data_byte),
    .byte_data  (in_data),
    .last_byte  (last_byte),
    .word_valid (word_valid),
    .word_data  (word_data)
  );

  // The packer's registered pulse and word are the write strobe and data:
  // they become valid on the same edge as the fourth byte.
  assign imem_we    = word_valid;
  assign imem_wdata = word_data;
  assign imem_addr  = imem_addr_reg;
  assign core_rst   = core_rst_reg;
  assign done       = done_reg;
  assign err        = err_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= PL_LEN_LO;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      PL_LEN_LO: begin
        if (transfer) state_next = PL_LEN_HI;
      end
      PL_LEN_HI: begin
        if (transfer) begin
          if (hdr_len == 16'd0)  state_next = PL_DONE;
          else if (hdr_oversize) state_next = PL_ERR;
          else                   state_next = PL_DATA;
        end
      end
      PL_DATA: begin
        if (word_done && last_word) state_next = PL_DONE;
      end
      PL_DONE:  state_next = PL_DONE;
      PL_ERR:   state_next = PL_ERR;
      default:  state_next = PL_LEN_LO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      len_lo_reg    <= '0;
      len_reg       <= '0;
      word_cnt_reg  <= '0;
      imem_addr_reg <= '0;
      core_rst_reg  <= 1'b1;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      if ((state_reg == PL_LEN_LO) && transfer) begin
        len_lo_reg <= in_data;
      end
      if ((state_reg == PL_LEN_HI) && transfer) begin
        len_reg <= hdr_len;
      end
      if (start_data) begin
        word_cnt_reg <= '0;
      end else if (word_done) begin
        imem_addr_reg <= word_cnt_reg[ADDR_W-1:0];
        word_cnt_reg  <= word_cnt_reg + 1'b1;
      end
      // Status follows the state one edge later, so the release happens
      // only after the final write has committed.
      core_rst_reg <= (state_reg != PL_DONE);
      done_reg     <= (state_reg == PL_DONE);
      err_reg      <= (state_reg == PL_ERR);
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader
// Self-checking bench for prog_loader. Expected writes are pushed to a
// scoreboard queue as words are driven and popped by a monitor on each
// imem_we pulse. Outputs are sampled on the falling clock edge.
module tb_prog_loader;

  localparam int DEPTH = 256;
  localparam int AW    = 8;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst;
  logic          done;
  logic          err;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   wr_count = 0;
  int   last_addr = -1;
  exp_t sb_q[$];
  int   wr_cyc_q[$];

  prog_loader #(.IMEM_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (imem_we) begin
      exp_t e;
      wr_count++;
      wr_cyc_q.push_back(cyc);
      last_addr = int'(imem_addr);
      check("write_expected", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("wr_addr", 64'(imem_addr), 64'(e.addr));
        check("wr_data", 64'(imem_wdata), 64'(e.data));
        $display("write addr=%0d data=0x%08h expected addr=%0d data=0x%08h",
                 imem_addr, imem_wdata, e.addr, e.data);
      end
    end
  end

  // Drive one byte (after an optional random gap) and wait, bounded, for it
  // to transfer. Returns on the falling edge after the transfer edge.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    bit ok;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("handshake_timeout", 64'(ok), 64'd1);
  endtask

  task automatic send_word(input logic [AW-1:0] addr, input logic [31:0] w, input int max_gap);
    exp_t e;
    e.addr = addr;
    e.data = w;
    sb_q.push_back(e);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], max_gap);
  endtask

  // Offer bytes that must not be accepted.
  task automatic offer_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready",   64'(in_ready),   64'd0);
    check("rst_imem_we",    64'(imem_we),    64'd0);
    check("rst_imem_addr",  64'(imem_addr),  64'd0);
    check("rst_imem_wdata", 64'(imem_wdata), 64'd0);
    check("rst_core_rst",   64'(core_rst),   64'd1);
    check("rst_done",       64'(done),       64'd0);
    check("rst_err",        64'(err),        64'd0);
    sb_q.delete();
    wr_cyc_q.delete();
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_three_words(input int max_gap);
    send_byte(8'h03, max_gap);
    send_byte(8'h00, max_gap);
    send_word(8'd0, 32'h00A00513, max_gap);
    send_word(8'd1, 32'h00500593, max_gap);
    send_word(8'd2, 32'h00B506B3, max_gap);
    in_valid = 1'b0;
  endtask

  initial begin
    int wc;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Three-word image, back-to-back.
    apply_reset();
    send_three_words(0);
    check("b2b_core_rst_at_last_write", 64'(core_rst), 64'd1);
    check("b2b_done_at_last_write",     64'(done),     64'd0);
    @(negedge clk);
    check("b2b_core_rst_released", 64'(core_rst), 64'd0);
    check("b2b_done",              64'(done),     64'd1);
    check("b2b_in_ready_done",     64'(in_ready), 64'd0);
    check("b2b_write_count", 64'(wr_cyc_q.size()), 64'd3);
    if (wr_cyc_q.size() == 3) begin
      check("b2b_spacing_01", 64'(wr_cyc_q[1] - wr_cyc_q[0]), 64'd4);
      check("b2b_spacing_12", 64'(wr_cyc_q[2] - wr_cyc_q[1]), 64'd4);
    end
    check("b2b_sb_empty", 64'(sb_q.size()), 64'd0);

    // Same image with random gaps.
    apply_reset();
    wc = wr_count;
    send_three_words(5);
    @(negedge clk);
    check("gap_write_count", 64'(wr_count - wc), 64'd3);
    check("gap_done",        64'(done),          64'd1);
    check("gap_core_rst",    64'(core_rst),      64'd0);
    check("gap_sb_empty",    64'(sb_q.size()),   64'd0);

    // Empty image.
    apply_reset();
    wc = wr_count;
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    in_valid = 1'b0;
    check("empty_in_ready", 64'(in_ready), 64'd0);
    check("empty_done_early", 64'(done), 64'd0);
    check("empty_core_rst_early", 64'(core_rst), 64'd1);
    @(negedge clk);
    check("empty_done",     64'(done),          64'd1);
    check("empty_core_rst", 64'(core_rst),      64'd0);
    check("empty_no_write", 64'(wr_count - wc), 64'd0);

    // Oversized header: N = 257.
    apply_reset();
    wc = wr_count;
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    in_valid = 1'b0;
    check("err_in_ready", 64'(in_ready), 64'd0);
    check("err_early",    64'(err),      64'd0);
    @(negedge clk);
    check("err_set",      64'(err),      64'd1);
    check("err_core_rst", 64'(core_rst), 64'd1);
    check("err_done",     64'(done),     64'd0);
    offer_bytes(8);
    check("err_no_write", 64'(wr_count - wc), 64'd0);
    check("err_hold",     64'(err),           64'd1);

    // Reset mid-load, then a fresh one-word stream.
    apply_reset();
    send_byte(8'h03, 0);
    send_byte(8'h00, 0);
    send_word(8'd0, 32'h00A00513, 0);
    send_word(8'd1, 32'h00500593, 0);
    send_byte(8'h93, 0);
    check("midload_sb_empty", 64'(sb_q.size()), 64'd0);
    apply_reset();
    wc = wr_count;
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_word(8'd0, 32'hDEADBEEF, 0);
    in_valid = 1'b0;
    @(negedge clk);
    check("reload_write_count", 64'(wr_count - wc), 64'd1);
    check("reload_done",        64'(done),          64'd1);
    check("reload_sb_empty",    64'(sb_q.size()),   64'd0);

    // Full-depth image.
    apply_reset();
    wc = wr_count;
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    for (int i = 0; i < DEPTH; i++) begin
      send_word(AW'(i), $urandom, 0);
      if (i == DEPTH - 1) begin
        check("full_done_early", 64'(done), 64'd0);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("full_write_count", 64'(wr_count - wc), 64'(DEPTH));
    check("full_last_addr",   64'(last_addr),     64'(DEPTH - 1));
    check("full_done",        64'(done),          64'd1);
    check("full_core_rst",    64'(core_rst),      64'd0);
    wc = wr_count;
    offer_bytes(4);
    repeat (2) @(negedge clk);
    check("full_extra_ignored", 64'(wr_count - wc), 64'd0);
    check("full_sb_empty",      64'(sb_q.size()),   64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
